// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types, opcodes, mux encodings and per-state control table for mc_control_fsm
package mc_pkg;

   typedef enum logic [3:0] {
      S_BOOT, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
      S_R_EXEC, S_R_WB, S_ADDI_EXEC, S_ADDI_WB, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      CLS_R, CLS_MEM, CLS_BRANCH, CLS_JUMP, CLS_ADDI, CLS_ILLEGAL
   } op_class_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ALUSRCB_REGB     = 2'b00;
   localparam logic [1:0] ALUSRCB_CONST4   = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM      = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SHL2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUREG = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_TRAP   = 2'b11;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src_a;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       pc_write;
      logic       ir_write;
      logic       i_or_d;
      logic [1:0] alu_op;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic       trap;
   } ctrl_t;

   // Moore output table: every strobe is a pure function of the state.
   function automatic ctrl_t ctrl_for(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.alu_src_b = ALUSRCB_CONST4;
            c.alu_op    = ALUOP_ADD;
            c.pc_source = PCSRC_ALU;
         end
         S_DECODE:    c.alu_src_b = ALUSRCB_IMM_SHL2;
         S_MEM_ADDR, S_ADDI_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = ALUSRCB_IMM;
         end
         S_MEM_READ:  begin c.mem_read  = 1'b1; c.i_or_d = 1'b1; end
         S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         S_MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
         S_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = ALUSRCB_REGB;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         S_ADDI_WB:   c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = ALUSRCB_REGB;
            c.alu_op    = ALUOP_SUB;
            c.branch    = 1'b1;
            c.pc_source = PCSRC_ALUREG;
         end
         S_JUMP:      begin c.pc_write = 1'b1; c.pc_source = PCSRC_JUMP; end
         S_TRAP:      begin c.pc_write = 1'b1; c.pc_source = PCSRC_TRAP; c.trap = 1'b1; end
         default:     c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// rtl/mc_opcode_decode.sv - combinational opcode to instruction-class lookup, consulted in DECODE
module mc_opcode_decode
   import mc_pkg::*;
(
   input  logic [5:0] opcode,
   output op_class_t  op_class
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      case (opcode)
         OP_RTYPE:     op_class = CLS_R;
         OP_LW, OP_SW: op_class = CLS_MEM;
         OP_BEQ:       op_class = CLS_BRANCH;
         OP_J:         op_class = CLS_JUMP;
         OP_ADDI:      op_class = CLS_ADDI;
         default:      op_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS-subset control FSM; MCCTRL_MEM_WAIT_EN adds mem_ready wait states
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter bit TRAP_VEC = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
`ifdef MCCTRL_MEM_WAIT_EN
   input  logic             mem_ready,
`endif
   output logic             reg_dst,
   output logic             alu_src_a,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             branch,
   output logic             pc_write,
   output logic             ir_write,
   output logic             i_or_d,
   output logic [1:0]       alu_op,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_source,
   output logic             trap,
   output logic [CNT_W-1:0] retired
);

   state_t     state;
   state_t     nxt;
   logic [5:0] op_q;
   ctrl_t      ctrl_q;
   op_class_t  op_class;
   logic       mem_go;
   logic       retire_evt;

`ifdef MCCTRL_MEM_WAIT_EN
   assign mem_go = mem_ready;
`else
   assign mem_go = 1'b1;
`endif

   mc_opcode_decode u_decode (
      .opcode   (opcode),
      .op_class (op_class)
   );

   always_comb begin
      nxt = state;
      case (state)
         S_BOOT:      nxt = S_FETCH;
         S_FETCH:     if (mem_go) nxt = S_DECODE;
         S_DECODE: begin
            case (op_class)
               CLS_R:      nxt = S_R_EXEC;
               CLS_MEM:    nxt = S_MEM_ADDR;
               CLS_BRANCH: nxt = S_BRANCH;
               CLS_JUMP:   nxt = S_JUMP;
               CLS_ADDI:   nxt = S_ADDI_EXEC;
               default:    nxt = TRAP_VEC ? S_TRAP : S_FETCH;
            endcase
         end
         S_MEM_ADDR:  nxt = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (mem_go) nxt = S_MEM_WB;
         S_MEM_WRITE: if (mem_go) nxt = S_FETCH;
         S_R_EXEC:    nxt = S_R_WB;
         S_ADDI_EXEC: nxt = S_ADDI_WB;
         S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP, S_TRAP: nxt = S_FETCH;
         default:     nxt = S_BOOT;
      endcase
   end

   // A FETCH->FETCH hold is a wait state, not a completed instruction.
   assign retire_evt = (nxt == S_FETCH) &&
                       !(state inside {S_BOOT, S_TRAP, S_FETCH});

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_BOOT;
         ctrl_q  <= '0;
         op_q    <= '0;
         retired <= '0;
      end else begin
         state  <= nxt;
         ctrl_q <= ctrl_for(nxt);
         if (state == S_DECODE) op_q <= opcode;
         if (retire_evt) retired <= retired + CNT_W'(1);
      end
   end

   assign reg_dst    = ctrl_q.reg_dst;
   assign alu_src_a  = ctrl_q.alu_src_a;
   assign mem_to_reg = ctrl_q.mem_to_reg;
   assign reg_write  = ctrl_q.reg_write;
   assign mem_read   = ctrl_q.mem_read;
   assign mem_write  = ctrl_q.mem_write;
   assign branch     = ctrl_q.branch;
   assign i_or_d     = ctrl_q.i_or_d;
   assign alu_op     = ctrl_q.alu_op;
   assign alu_src_b  = ctrl_q.alu_src_b;
   assign pc_source  = ctrl_q.pc_source;
   assign trap       = ctrl_q.trap;

`ifdef MCCTRL_MEM_WAIT_EN
   // IR load and PC increment only on the cycle the fetch data is actually valid.
   assign ir_write = ctrl_q.ir_write & ((state != S_FETCH) | mem_ready);
   assign pc_write = ctrl_q.pc_write & ((state != S_FETCH) | mem_ready);
`else
   assign ir_write = ctrl_q.ir_write;
   assign pc_write = ctrl_q.pc_write;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench for mc_control_fsm with per-instruction phase model
module tb_mc_control_fsm;

   localparam int CW = 4;

   typedef enum {P_BOOT, P_FETCH, P_DECODE, P_MADDR, P_MRD, P_MWB, P_MWR,
                 P_REX, P_RWB, P_AEX, P_AWB, P_BR, P_JMP, P_TRAP} ph_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    opcode;
   logic          mem_ready;
   logic          reg_dst, alu_src_a, mem_to_reg, reg_write, mem_read, mem_write;
   logic          branch, pc_write, ir_write, i_or_d, trap;
   logic [1:0]    alu_op, alu_src_b, pc_source;
   logic [CW-1:0] retired;

   int            total = 0;
   int            bad = 0;
   logic [CW-1:0] exp_ret;

   always #5 clk = ~clk;

   mc_control_fsm #(.CNT_W(CW), .TRAP_VEC(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
`ifdef MCCTRL_MEM_WAIT_EN
      .mem_ready  (mem_ready),
`endif
      .reg_dst    (reg_dst),
      .alu_src_a  (alu_src_a),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .branch     (branch),
      .pc_write   (pc_write),
      .ir_write   (ir_write),
      .i_or_d     (i_or_d),
      .alu_op     (alu_op),
      .alu_src_b  (alu_src_b),
      .pc_source  (pc_source),
      .trap       (trap),
      .retired    (retired)
   );

   function automatic logic [16:0] w(input logic rd, as, mr, rw, mrd, mwr, br, pw, iw, id,
                                     input logic [1:0] aop, bsel, pcs, input logic tp);
      return {rd, as, mr, rw, mrd, mwr, br, pw, iw, id, aop, bsel, pcs, tp};
   endfunction

   // Expected strobes for each phase, written straight from the phase descriptions.
   function automatic logic [16:0] exp_word(input ph_t p, input logic rdy);
      case (p)
         P_FETCH:  return w(0,0,0,0,1,0,0,rdy,rdy,0, 2'b00,2'b01,2'b00,0);
         P_DECODE: return w(0,0,0,0,0,0,0,0,0,0,     2'b00,2'b11,2'b00,0);
         P_MADDR:  return w(0,1,0,0,0,0,0,0,0,0,     2'b00,2'b10,2'b00,0);
         P_MRD:    return w(0,0,0,0,1,0,0,0,0,1,     2'b00,2'b00,2'b00,0);
         P_MWB:    return w(0,0,1,1,0,0,0,0,0,0,     2'b00,2'b00,2'b00,0);
         P_MWR:    return w(0,0,0,0,0,1,0,0,0,1,     2'b00,2'b00,2'b00,0);
         P_REX:    return w(0,1,0,0,0,0,0,0,0,0,     2'b10,2'b00,2'b00,0);
         P_RWB:    return w(1,0,0,1,0,0,0,0,0,0,     2'b00,2'b00,2'b00,0);
         P_AEX:    return w(0,1,0,0,0,0,0,0,0,0,     2'b00,2'b10,2'b00,0);
         P_AWB:    return w(0,0,0,1,0,0,0,0,0,0,     2'b00,2'b00,2'b00,0);
         P_BR:     return w(0,1,0,0,0,0,1,0,0,0,     2'b01,2'b00,2'b01,0);
         P_JMP:    return w(0,0,0,0,0,0,0,1,0,0,     2'b00,2'b00,2'b10,0);
         P_TRAP:   return w(0,0,0,0,0,0,0,1,0,0,     2'b00,2'b00,2'b11,1);
         default:  return '0;
      endcase
   endfunction

   function automatic logic cur_rdy();
`ifdef MCCTRL_MEM_WAIT_EN
      return mem_ready;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic is_mem_phase(input ph_t p);
      return (p == P_FETCH) || (p == P_MRD) || (p == P_MWR);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input ph_t p);
      logic [16:0] obs;
      logic [16:0] exp;
      obs = {reg_dst, alu_src_a, mem_to_reg, reg_write, mem_read, mem_write, branch,
             pc_write, ir_write, i_or_d, alu_op, alu_src_b, pc_source, trap};
      exp = exp_word(p, cur_rdy());
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s ctrl phase=%s got=%05h exp=%05h", tag, p.name(), obs, exp);
      end
      total++;
      assert (retired === exp_ret) else begin
         bad++;
         $error("FAIL %s retired phase=%s got=%0d exp=%0d", tag, p.name(), retired, exp_ret);
      end
      total++;
      assert (((mem_read & mem_write) | (reg_write & mem_write)) === 1'b0) else begin
         bad++;
         $error("FAIL %s exclusive rd=%b wr=%b rw=%b exp=no overlap", tag, mem_read, mem_write, reg_write);
      end
   endtask

   // Runs one instruction starting in its FETCH cycle; leaves the bench in the next FETCH cycle.
   task automatic run_instr(input logic [5:0] op, input int fetch_wait, input string tag);
      ph_t  q[$];
      int   i;
      int   waits;
      logic hold;
      q = {P_FETCH, P_DECODE};
      case (op)
         6'h23:   begin q.push_back(P_MADDR); q.push_back(P_MRD); q.push_back(P_MWB); end
         6'h2B:   begin q.push_back(P_MADDR); q.push_back(P_MWR); end
         6'h00:   begin q.push_back(P_REX); q.push_back(P_RWB); end
         6'h08:   begin q.push_back(P_AEX); q.push_back(P_AWB); end
         6'h04:   q.push_back(P_BR);
         6'h02:   q.push_back(P_JMP);
         default: q.push_back(P_TRAP);
      endcase
      i = 0;
      waits = fetch_wait;
      while (i < q.size()) begin
         if (q[i] == P_FETCH && waits > 0) begin
            mem_ready = 1'b0;
            waits--;
         end else if (is_mem_phase(q[i]) && fetch_wait < 0) begin
            mem_ready = ($urandom_range(0, 3) != 0);
         end else begin
            mem_ready = 1'b1;
         end
         if (q[i] == P_FETCH) opcode = op;
         #1;
         chk(tag, q[i]);
         hold = is_mem_phase(q[i]) && !cur_rdy();
         step();
         if (q[i] == P_DECODE) opcode = 6'($urandom);
         if (!hold) i++;
      end
      if (q[q.size()-1] != P_TRAP) exp_ret = exp_ret + 1'b1;
   endtask

   initial begin
      logic [5:0] ops [7];
      logic [5:0] op;
      ops = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02, 6'h3F};
      rst = 1'b1;
      opcode = 6'h00;
      mem_ready = 1'b1;
      exp_ret = '0;

      step(); step(); step();
      chk("reset", P_BOOT);
      rst = 1'b0;
      #1;
      chk("boot", P_BOOT);
      step();

      run_instr(6'h23, 0, "lw");
      run_instr(6'h2B, 0, "sw");
      run_instr(6'h00, 0, "rtype");
      run_instr(6'h04, 0, "beq");
      run_instr(6'h02, 0, "j");
      run_instr(6'h3F, 0, "trap");
      run_instr(6'h08, 0, "addi");
`ifdef MCCTRL_MEM_WAIT_EN
      run_instr(6'h23, 4, "lw_wait");
`endif

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 4) == 0) op = 6'($urandom);
         else op = ops[$urandom_range(0, 6)];
         run_instr(op, -1, "rand");
      end

      // Reset while an LW sits in MEM_ADDR.
      mem_ready = 1'b1;
      opcode = 6'h23;
      #1; chk("rst_mid", P_FETCH);
      step(); chk("rst_mid", P_DECODE);
      step(); opcode = 6'h00; chk("rst_mid", P_MADDR);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_ret = '0;
      chk("rst_mid_boot", P_BOOT);
      step();
      run_instr(6'h23, 0, "lw_after_rst");
      run_instr(6'h2B, 0, "sw_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
